// File: rtl/pmips_pkg.sv
// Shared opcode and FSM state encodings for the pMIPS execute/write-back stage.
package pmips_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_LDI  = 3'd5,
    OP_ADDI = 3'd6,
    OP_MUL  = 3'd7
  } exec_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WB   = 2'd2
  } exec_state_t;

endpackage

// File: rtl/pmips_mul_seq.sv
// Iterative shift-add multiplier: load latches operands, each step consumes one
// multiplier bit; o_result already includes the current step's partial product.
module pmips_mul_seq #(
  parameter int n = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  output logic         o_done,
  output logic [n-1:0] o_result
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;

  logic [n-1:0]  r_mcand;
  logic [n-1:0]  r_mplier;
  logic [n-1:0]  r_acc;
  logic [CW-1:0] r_cnt;

  assign o_result = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done   = i_step && (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CW'(n - 1);
    end else if (i_step) begin
      r_acc    <= o_result;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pmips_exec.sv
// pMIPS execute/write-back stage: single-cycle ALU ops plus an n-cycle MUL,
// driving the register file write port with a one-cycle w pulse.
module pmips_exec #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [4:0]   rd_sel,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [n-1:0] imm,
  output logic         busy,
  output logic         w,
  output logic [n-1:0] Wdata,
  output logic [4:0]   rd,
  output logic         zero
);

  import pmips_pkg::*;

  exec_state_t  r_state;
  exec_state_t  w_next;
  exec_op_t     w_op;
  logic [n-1:0] w_alu;
  logic         w_load;
  logic         w_done;
  logic [n-1:0] w_mul_res;
  logic [n-1:0] r_wdata;
  logic [4:0]   r_rd;
  logic [4:0]   r_rd_pend;
  logic         r_zero;

  assign w_op = exec_op_t'(op);

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = a + b;
      OP_SUB:  w_alu = a - b;
      OP_AND:  w_alu = a & b;
      OP_OR:   w_alu = a | b;
      OP_XOR:  w_alu = a ^ b;
      OP_LDI:  w_alu = imm;
      OP_ADDI: w_alu = a + imm;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_op == OP_MUL) begin
            w_next = S_MUL;
            w_load = 1'b1;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_MUL:   if (w_done) w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  pmips_mul_seq #(.n(n)) u_mul (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_load   (w_load),
    .i_step   (r_state == S_MUL),
    .i_a      (a),
    .i_b      (b),
    .o_done   (w_done),
    .o_result (w_mul_res)
  );

  // MUL destination is parked until completion so rd only changes entering WB
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdata   <= '0;
      r_rd      <= '0;
      r_rd_pend <= '0;
      r_zero    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_op == OP_MUL) begin
              r_rd_pend <= rd_sel;
            end else begin
              r_wdata <= w_alu;
              r_rd    <= rd_sel;
            end
          end
        end
        S_MUL: begin
          if (w_done) begin
            r_wdata <= w_mul_res;
            r_rd    <= r_rd_pend;
          end
        end
        S_WB:    r_zero <= (r_wdata == '0);
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign w     = (r_state == S_WB) && (r_rd != '0);
  assign Wdata = r_wdata;
  assign rd    = r_rd;
  assign zero  = r_zero;

endmodule

// File: tb/tb_pmips_exec.sv
// Self-checking bench for pmips_exec: directed literal cases plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_pmips_exec;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [4:0]   rd_sel = '0;
  logic [N-1:0] a = '0, b = '0, imm = '0;
  logic         busy, w, zero;
  logic [N-1:0] Wdata;
  logic [4:0]   rd;

  pmips_exec #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rd_sel(rd_sel),
    .a(a), .b(b), .imm(imm), .busy(busy), .w(w), .Wdata(Wdata),
    .rd(rd), .zero(zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_result(input int o, input int x, input int y, input int i);
    int r;
    case (o)
      0: r = x + y;
      1: r = x - y;
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = i;
      6: r = x + i;
      default: r = x * y;
    endcase
    return N'(r);
  endfunction

  // Model: m_cnt = busy cycles remaining; the final one is the write-back cycle.
  int         m_cnt = 0;
  logic [N-1:0] m_wdata = '0, m_pend = '0;
  logic [4:0] m_rd = '0, m_prd = '0;
  logic       m_zero = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0; m_wdata = '0; m_pend = '0; m_rd = '0; m_prd = '0; m_zero = 1'b0;
    end else if (m_cnt == 0) begin
      if (start === 1'b1) begin
        if (op == 3'd7) begin
          m_pend = ref_result(op, a, b, imm);
          m_prd  = rd_sel;
          m_cnt  = N + 1;
        end else begin
          m_wdata = ref_result(op, a, b, imm);
          m_rd    = rd_sel;
          m_cnt   = 1;
        end
      end
    end else begin
      if (m_cnt == 1) m_zero = (m_wdata == 0);
      else if (m_cnt == 2) begin
        m_wdata = m_pend;
        m_rd    = m_prd;
      end
      m_cnt--;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_cnt != 0);
      chk("w", w, (m_cnt == 1) && (m_rd != 0));
      chk("Wdata", Wdata, m_wdata);
      chk("rd", rd, m_rd);
      chk("zero", zero, m_zero);
    end
  end

  task automatic scramble();
    a = N'($urandom); b = N'($urandom); imm = N'($urandom);
    op = 3'($urandom); rd_sel = 5'($urandom);
  endtask

  task automatic issue(input int o, input int x, input int y, input int i, input int r);
    start = 1'b1; op = 3'(o); a = N'(x); b = N'(y); imm = N'(i); rd_sel = 5'(r);
    @(negedge clk);
    start = 1'b0;
    scramble();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy === 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic mul_run(input int x, input int y, input int exp, input bit ign);
    int bc = 0;
    int wp = 0;
    issue(7, x, y, 0, 9);
    while (busy === 1'b1 && bc < 40) begin
      bc++;
      if (w === 1'b1) begin
        wp++;
        chk("mul_wdata", Wdata, exp);
        chk("mul_rd", rd, 9);
      end
      start = ign && bc >= 2 && bc <= 5;
      op = 3'd0; a = 1; b = 1; rd_sel = 5'd3;
      @(negedge clk);
    end
    start = 1'b0;
    chk("mul_busy_cycles", bc, N + 1);
    chk("mul_w_pulses", wp, 1);
    chk("mul_final", Wdata, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_w", w, 0);
    chk("rst_wdata", Wdata, 0);
    chk("rst_rd", rd, 0);
    chk("rst_zero", zero, 0);
    reset = 1'b0;
    @(negedge clk);

    issue(0, 3, 11, 0, 6);
    chk("add_w", w, 1); chk("add_wdata", Wdata, 14); chk("add_rd", rd, 6); chk("add_busy", busy, 1);
    @(negedge clk);
    chk("add_busy_end", busy, 0); chk("add_zero", zero, 0);

    issue(1, 3, 11, 0, 2);
    chk("sub_neg", Wdata, 8'hF8);
    @(negedge clk);
    issue(1, 5, 5, 0, 2);
    chk("sub_zero_wdata", Wdata, 0);
    @(negedge clk);
    chk("sub_zero_flag", zero, 1);

    issue(5, 0, 0, 8'h3C, 1);
    chk("ldi_wdata", Wdata, 8'h3C); chk("ldi_rd", rd, 1);
    @(negedge clk);

    mul_run(13, 11, 8'h8F, 1'b0);
    mul_run(20, 20, 8'h90, 1'b0);

    issue(0, 3, 4, 0, 0);
    chk("rd0_w", w, 0); chk("rd0_busy", busy, 1); chk("rd0_wdata", Wdata, 7);
    @(negedge clk);
    chk("rd0_busy_end", busy, 0);

    mul_run(13, 11, 8'h8F, 1'b1);

    issue(7, 13, 11, 0, 4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_busy", busy, 0); chk("mrst_w", w, 0); chk("mrst_wdata", Wdata, 0);
    chk("mrst_rd", rd, 0); chk("mrst_zero", zero, 0);
    issue(0, 1, 1, 0, 5);
    chk("post_rst_w", w, 1); chk("post_rst_wdata", Wdata, 2);
    @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      scramble();
      start = ($urandom % 3) == 0;
      reset = ($urandom % 64) == 0;
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
